mem_rd_arbiter: RTL and testbench
=================================

# mem_rd_arbiter

Two-master read-channel arbiter in front of the single memory read port. It shares the port between instruction fetch (IF, driven by the PC unit's fetch handshake) and the load path of the LSU. It accepts one AR request at a time and forwards it to memory. The R response is routed back to the owning master. Round-robin priority prevents either master starving the other.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- if_arvalid  in  1  IF read-address valid
- if_arready  out  1  IF read-address accepted
- if_araddr  in  ADDR_W  IF fetch address
- if_rvalid  out  1  IF read-data valid
- if_rready  in  1  IF ready for data
- if_rdata  out  DATA_W  IF read data
- if_rresp  out  2  IF read response
- lsu_arvalid  in  1  LSU read-address valid
- lsu_arready  out  1  LSU read-address accepted
- lsu_araddr  in  ADDR_W  LSU load address
- lsu_rvalid  out  1  LSU read-data valid
- lsu_rready  in  1  LSU ready for data
- lsu_rdata  out  DATA_W  LSU read data
- lsu_rresp  out  2  LSU read response
- mem_arvalid  out  1  memory read-address valid
- mem_arready  in  1  memory accepts address
- mem_araddr  out  ADDR_W  memory address
- mem_rvalid  in  1  memory data valid
- mem_rready  out  1  arbiter ready for memory data
- mem_rdata  in  DATA_W  memory data
- mem_rresp  in  2  memory response
- grant  out  1  current owner: 0 = IF, 1 = LSU; valid while busy
- busy  out  1  a transaction is in flight

## Operation
States and transitions:
- IDLE → AR: when any arvalid is high.
- AR → R: on mem_arvalid & mem_arready.
- R → IDLE: on mem_rvalid & mem_rready.

IDLE behaviour:
- Grant is decided combinationally from arvalid, as follows:
  - Only one master requesting: that master is granted.
  - Both requesting: grant goes to the master ≠ last_grant.
- The granted master's arready is 1 in the same cycle. Its araddr is captured into the addr register, grant is registered, and last_grant ← grant.
- The non-granted arready is 0.
- Neither arready is ever 1 outside IDLE.

AR behaviour:
- mem_arvalid = 1.
- mem_araddr = captured addr, held stable until the handshake completes.

R behaviour:
- mem_rvalid is routed to the granted master's rvalid. The other master's rvalid is 0.
- mem_rready = granted master's rready.
- rdata and rresp pass through to both masters. Only the owner's rvalid qualifies them.
- mem_rresp is passed through unmodified; an error response does not alter the sequence.

Masters never cancel a request:
- An accepted IF request whose result the PC unit discards is still completed.
- IF must still handshake R to release the port.

Other outputs:
- busy = (state ≠ IDLE).
- mem_rready = 0 outside R.

Reset (also applies mid-transaction):
- state ← IDLE, last_grant ← 1 (LSU), so IF wins the first tie; addr ← 0, grant ← 0.
- All valid/ready outputs are 0 the cycle after rst, except arready, which follows the IDLE combinational rule.
- An in-flight memory response is abandoned; memory shares the same rst.

## Timing
- Request accepted in cycle N (arvalid & arready) → mem_arvalid = 1 in cycle N+1.
- Zero-wait memory gives minimum read latency: AR handshake at N+1, R handshake at N+2 when mem_rvalid and the owner's rready are both 1.
- R handshake in cycle M → IDLE at M+1. The next request can be accepted at M+1, giving one bubble cycle between transactions.
- mem_arready stall: remain in AR with mem_araddr/mem_arvalid unchanged.
- Owner rready low: remain in R. mem_rready stays low, and memory must hold rdata.
- Non-owner arvalid raised mid-transaction: it waits with arready = 0. It is the sole or priority candidate at the next IDLE.

## Test plan
- IF alone, araddr 0x80000000, mem returns 0x00000413 with zero wait → if_arready at N, mem_arvalid at N+1, if_rvalid/if_rdata = 0x00000413 at N+2, lsu_rvalid = 0 throughout, grant = 0.
- Both request at the first cycle after reset (IF 0x80000004, LSU 0x80001000) → IF granted first, then LSU at M+1. With both held continuously, grants alternate 0,1,0,1 over 4 transactions.
- mem_arready held low 3 cycles → mem_araddr stable for 4 cycles, busy = 1, both arready = 0 until return to IDLE.
- LSU owner with lsu_rready low for 2 cycles while mem_rvalid = 1 → mem_rready = 0 for those cycles; the transaction completes on the cycle lsu_rready rises; rdata is delivered once.
- mem_rresp = 2'b10 on an IF read → if_rresp = 2'b10, normal return to IDLE.
- rst asserted in R state → next cycle state IDLE, mem_arvalid = 0, mem_rready = 0, busy = 0, both rvalid = 0; a subsequent simultaneous request grants IF.

Source files
------------

// File: rtl/mem_rd_arbiter_if.sv
// Read-channel bundle (AR + R) between a requester (master) and a responder (slave).
// Used for the IF, LSU and memory sides of the read arbiter.
interface mem_rd_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output arvalid, araddr, rready,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    input  arvalid, araddr, rready,
    output arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/mem_rd_arbiter.sv
// Round-robin arbiter sharing one memory read port between instruction fetch and LSU loads.
// One transaction in flight at a time; the R beat is routed back to the owning master.
module mem_rd_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_rd_arbiter_if.slave       if_bus,
  mem_rd_arbiter_if.slave       lsu_bus,
  mem_rd_arbiter_if.master      mem_bus,
  output logic                  grant,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StAr, StR} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              mem_arvalid_q, mem_arvalid_d;
  logic              busy_q, busy_d;

  logic idle;
  logic any_req;
  logic pick_lsu;
  logic mem_rready;

  assign idle    = (state_q == StIdle);
  assign any_req = if_bus.arvalid | lsu_bus.arvalid;
  // On a tie the master that did not win last time gets the port.
  assign pick_lsu = lsu_bus.arvalid & (~if_bus.arvalid | ~last_grant_q);

  assign if_bus.arready  = idle & if_bus.arvalid & ~pick_lsu;
  assign lsu_bus.arready = idle & pick_lsu;

  assign mem_rready = (state_q == StR) & (grant_q ? lsu_bus.rready : if_bus.rready);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d      = StAr;
          grant_d      = pick_lsu;
          last_grant_d = pick_lsu;
          addr_d       = pick_lsu ? lsu_bus.araddr : if_bus.araddr;
        end
      end
      StAr: begin
        if (mem_bus.arready) begin
          state_d = StR;
        end
      end
      StR: begin
        if (mem_bus.rvalid & mem_rready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    mem_arvalid_d = (state_d == StAr);
    busy_d        = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      grant_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      mem_arvalid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      mem_arvalid_q <= mem_arvalid_d;
      busy_q        <= busy_d;
    end
  end

  assign mem_bus.arvalid = mem_arvalid_q;
  assign mem_bus.araddr  = addr_q;
  assign mem_bus.rready  = mem_rready;

  assign if_bus.rvalid  = (state_q == StR) & ~grant_q & mem_bus.rvalid;
  assign lsu_bus.rvalid = (state_q == StR) & grant_q & mem_bus.rvalid;
  assign if_bus.rdata   = mem_bus.rdata;
  assign lsu_bus.rdata  = mem_bus.rdata;
  assign if_bus.rresp   = mem_bus.rresp;
  assign lsu_bus.rresp  = mem_bus.rresp;

  assign grant = grant_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed self-checking bench for mem_rd_arbiter: single requests, round-robin ties,
// memory stalls, owner back-pressure, error responses and reset mid-transaction.
module tb_mem_rd_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic clk = 1'b0;
  logic rst;
  logic grant;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  mem_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if_bus ();
  mem_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) lsu_bus ();
  mem_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

  mem_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .if_bus  (if_bus),
    .lsu_bus (lsu_bus),
    .mem_bus (mem_bus),
    .grant   (grant),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs change here, checks follow a #1 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fail(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    errors++;
    $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    logic        exp_lsu;
    logic [31:0] exp_addr;

    rst             = 1'b1;
    if_bus.arvalid  = 1'b0;
    if_bus.araddr   = '0;
    if_bus.rready   = 1'b0;
    lsu_bus.arvalid = 1'b0;
    lsu_bus.araddr  = '0;
    lsu_bus.rready  = 1'b0;
    mem_bus.arready = 1'b0;
    mem_bus.rvalid  = 1'b0;
    mem_bus.rdata   = '0;
    mem_bus.rresp   = 2'b00;

    tick();
    tick();
    #1;
    checks++; if (busy !== 1'b0) fail("rst_busy", busy, 1'b0);
    checks++; if (grant !== 1'b0) fail("rst_grant", grant, 1'b0);
    checks++; if (mem_bus.arvalid !== 1'b0) fail("rst_mem_arvalid", mem_bus.arvalid, 1'b0);
    checks++; if (mem_bus.rready !== 1'b0) fail("rst_mem_rready", mem_bus.rready, 1'b0);
    checks++; if (if_bus.rvalid !== 1'b0) fail("rst_if_rvalid", if_bus.rvalid, 1'b0);
    checks++; if (lsu_bus.rvalid !== 1'b0) fail("rst_lsu_rvalid", lsu_bus.rvalid, 1'b0);
    checks++; if (mem_bus.araddr !== 32'h0) fail("rst_mem_araddr", mem_bus.araddr, 32'h0);
    rst = 1'b0;

    // IF alone, zero-wait memory.
    tick();
    if_bus.arvalid = 1'b1;
    if_bus.araddr  = 32'h8000_0000;
    if_bus.rready  = 1'b1;
    #1;
    checks++; if (if_bus.arready !== 1'b1) fail("a_if_arready", if_bus.arready, 1'b1);
    checks++; if (lsu_bus.arready !== 1'b0) fail("a_lsu_arready", lsu_bus.arready, 1'b0);
    checks++; if (busy !== 1'b0) fail("a_busy_idle", busy, 1'b0);
    tick();
    if_bus.arvalid  = 1'b0;
    mem_bus.arready = 1'b1;
    #1;
    checks++; if (mem_bus.arvalid !== 1'b1) fail("a_mem_arvalid", mem_bus.arvalid, 1'b1);
    checks++;
    if (mem_bus.araddr !== 32'h8000_0000) fail("a_mem_araddr", mem_bus.araddr, 32'h8000_0000);
    checks++; if (grant !== 1'b0) fail("a_grant", grant, 1'b0);
    checks++; if (busy !== 1'b1) fail("a_busy", busy, 1'b1);
    checks++; if (if_bus.arready !== 1'b0) fail("a_if_arready_ar", if_bus.arready, 1'b0);
    tick();
    mem_bus.arready = 1'b0;
    mem_bus.rvalid  = 1'b1;
    mem_bus.rdata   = 32'h0000_0413;
    #1;
    checks++; if (if_bus.rvalid !== 1'b1) fail("a_if_rvalid", if_bus.rvalid, 1'b1);
    checks++; if (if_bus.rdata !== 32'h0000_0413) fail("a_if_rdata", if_bus.rdata, 32'h0000_0413);
    checks++; if (lsu_bus.rvalid !== 1'b0) fail("a_lsu_rvalid", lsu_bus.rvalid, 1'b0);
    checks++; if (mem_bus.rready !== 1'b1) fail("a_mem_rready", mem_bus.rready, 1'b1);
    checks++; if (mem_bus.arvalid !== 1'b0) fail("a_mem_arvalid_r", mem_bus.arvalid, 1'b0);
    tick();
    mem_bus.rvalid = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) fail("a_busy_done", busy, 1'b0);
    checks++; if (if_bus.rvalid !== 1'b0) fail("a_if_rvalid_done", if_bus.rvalid, 1'b0);

    // Fresh reset, then both masters request continuously: grants alternate IF, LSU, IF, LSU.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if_bus.arvalid  = 1'b1;
    if_bus.araddr   = 32'h8000_0004;
    lsu_bus.arvalid = 1'b1;
    lsu_bus.araddr  = 32'h8000_1000;
    lsu_bus.rready  = 1'b1;
    mem_bus.arready = 1'b1;
    mem_bus.rvalid  = 1'b1;
    mem_bus.rdata   = 32'h1234_5678;
    for (int k = 0; k < 4; k++) begin
      exp_lsu  = k[0];
      exp_addr = exp_lsu ? 32'h8000_1000 : 32'h8000_0004;
      #1;
      checks++; if (if_bus.arready !== ~exp_lsu) fail("b_if_arready", if_bus.arready, ~exp_lsu);
      checks++; if (lsu_bus.arready !== exp_lsu) fail("b_lsu_arready", lsu_bus.arready, exp_lsu);
      tick();
      #1;
      checks++; if (grant !== exp_lsu) fail("b_grant", grant, exp_lsu);
      checks++; if (mem_bus.araddr !== exp_addr) fail("b_mem_araddr", mem_bus.araddr, exp_addr);
      checks++;
      if ((if_bus.arready | lsu_bus.arready) !== 1'b0) begin
        fail("b_arready_blocked", if_bus.arready | lsu_bus.arready, 1'b0);
      end
      tick();
      #1;
      checks++; if (if_bus.rvalid !== ~exp_lsu) fail("b_if_rvalid", if_bus.rvalid, ~exp_lsu);
      checks++; if (lsu_bus.rvalid !== exp_lsu) fail("b_lsu_rvalid", lsu_bus.rvalid, exp_lsu);
      tick();
    end

    // IF alone with mem_arready stalled 3 cycles; LSU raises a request mid-transaction.
    lsu_bus.arvalid = 1'b0;
    mem_bus.arready = 1'b0;
    mem_bus.rvalid  = 1'b0;
    if_bus.araddr   = 32'h8000_0008;
    #1;
    checks++; if (if_bus.arready !== 1'b1) fail("c_if_arready", if_bus.arready, 1'b1);
    tick();
    if_bus.arvalid  = 1'b0;
    if_bus.araddr   = 32'hDEAD_BEEF;
    lsu_bus.arvalid = 1'b1;
    lsu_bus.araddr  = 32'h8000_1010;
    for (int i = 0; i < 4; i++) begin
      mem_bus.arready = (i == 3);
      #1;
      checks++; if (mem_bus.arvalid !== 1'b1) fail("c_mem_arvalid", mem_bus.arvalid, 1'b1);
      checks++;
      if (mem_bus.araddr !== 32'h8000_0008) fail("c_mem_araddr", mem_bus.araddr, 32'h8000_0008);
      checks++; if (busy !== 1'b1) fail("c_busy", busy, 1'b1);
      checks++; if (if_bus.arready !== 1'b0) fail("c_if_arready", if_bus.arready, 1'b0);
      checks++; if (lsu_bus.arready !== 1'b0) fail("c_lsu_arready", lsu_bus.arready, 1'b0);
      tick();
    end
    // Error response on the IF read.
    mem_bus.arready = 1'b0;
    mem_bus.rvalid  = 1'b1;
    mem_bus.rdata   = 32'h0000_0BAD;
    mem_bus.rresp   = 2'b10;
    #1;
    checks++; if (if_bus.rvalid !== 1'b1) fail("e_if_rvalid", if_bus.rvalid, 1'b1);
    checks++; if (if_bus.rresp !== 2'b10) fail("e_if_rresp", if_bus.rresp, 2'b10);
    checks++; if (lsu_bus.rvalid !== 1'b0) fail("e_lsu_rvalid", lsu_bus.rvalid, 1'b0);
    checks++; if (lsu_bus.arready !== 1'b0) fail("e_lsu_arready", lsu_bus.arready, 1'b0);
    tick();
    mem_bus.rvalid = 1'b0;
    mem_bus.rresp  = 2'b00;
    #1;
    checks++; if (busy !== 1'b0) fail("e_busy_idle", busy, 1'b0);
    checks++; if (lsu_bus.arready !== 1'b1) fail("c_lsu_granted_next", lsu_bus.arready, 1'b1);
    checks++; if (if_bus.arready !== 1'b0) fail("c_if_not_granted", if_bus.arready, 1'b0);

    // LSU owner holds rready low for 2 cycles while memory data is valid.
    tick();
    lsu_bus.arvalid = 1'b0;
    lsu_bus.rready  = 1'b0;
    mem_bus.arready = 1'b1;
    #1;
    checks++; if (grant !== 1'b1) fail("d_grant", grant, 1'b1);
    checks++;
    if (mem_bus.araddr !== 32'h8000_1010) fail("d_mem_araddr", mem_bus.araddr, 32'h8000_1010);
    tick();
    mem_bus.arready = 1'b0;
    mem_bus.rvalid  = 1'b1;
    mem_bus.rdata   = 32'hCAFE_F00D;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (mem_bus.rready !== 1'b0) fail("d_mem_rready_low", mem_bus.rready, 1'b0);
      checks++; if (lsu_bus.rvalid !== 1'b1) fail("d_lsu_rvalid", lsu_bus.rvalid, 1'b1);
      checks++; if (busy !== 1'b1) fail("d_busy", busy, 1'b1);
      tick();
    end
    lsu_bus.rready = 1'b1;
    #1;
    checks++; if (mem_bus.rready !== 1'b1) fail("d_mem_rready_high", mem_bus.rready, 1'b1);
    checks++;
    if (lsu_bus.rdata !== 32'hCAFE_F00D) fail("d_lsu_rdata", lsu_bus.rdata, 32'hCAFE_F00D);
    checks++; if (if_bus.rvalid !== 1'b0) fail("d_if_rvalid", if_bus.rvalid, 1'b0);
    tick();
    #1;
    checks++; if (busy !== 1'b0) fail("d_busy_done", busy, 1'b0);
    checks++; if (lsu_bus.rvalid !== 1'b0) fail("d_lsu_rvalid_once", lsu_bus.rvalid, 1'b0);
    checks++; if (mem_bus.rready !== 1'b0) fail("d_mem_rready_idle", mem_bus.rready, 1'b0);

    // Reset while an IF read sits in R with the owner not ready.
    mem_bus.rvalid = 1'b0;
    if_bus.arvalid = 1'b1;
    if_bus.araddr  = 32'h8000_0010;
    if_bus.rready  = 1'b0;
    tick();
    if_bus.arvalid  = 1'b0;
    mem_bus.arready = 1'b1;
    tick();
    mem_bus.arready = 1'b0;
    mem_bus.rvalid  = 1'b1;
    #1;
    checks++; if (busy !== 1'b1) fail("r_busy_in_r", busy, 1'b1);
    checks++; if (if_bus.rvalid !== 1'b1) fail("r_if_rvalid_in_r", if_bus.rvalid, 1'b1);
    rst = 1'b1;
    tick();
    #1;
    checks++; if (busy !== 1'b0) fail("r_busy", busy, 1'b0);
    checks++; if (mem_bus.arvalid !== 1'b0) fail("r_mem_arvalid", mem_bus.arvalid, 1'b0);
    checks++; if (mem_bus.rready !== 1'b0) fail("r_mem_rready", mem_bus.rready, 1'b0);
    checks++; if (if_bus.rvalid !== 1'b0) fail("r_if_rvalid", if_bus.rvalid, 1'b0);
    checks++; if (lsu_bus.rvalid !== 1'b0) fail("r_lsu_rvalid", lsu_bus.rvalid, 1'b0);
    checks++; if (grant !== 1'b0) fail("r_grant", grant, 1'b0);
    rst             = 1'b0;
    mem_bus.rvalid  = 1'b0;
    if_bus.arvalid  = 1'b1;
    lsu_bus.arvalid = 1'b1;
    #1;
    checks++; if (if_bus.arready !== 1'b1) fail("r_tie_if_arready", if_bus.arready, 1'b1);
    checks++; if (lsu_bus.arready !== 1'b0) fail("r_tie_lsu_arready", lsu_bus.arready, 1'b0);
    tick();
    if_bus.arvalid  = 1'b0;
    lsu_bus.arvalid = 1'b0;
    #1;
    checks++; if (grant !== 1'b0) fail("r_tie_grant", grant, 1'b0);
    checks++;
    if (mem_bus.araddr !== 32'h8000_0010) begin
      fail("r_tie_mem_araddr", mem_bus.araddr, 32'h8000_0010);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
